// File: rtl/rr_arbiter8_if.sv
// Bus bundle between the eight requesters and the round-robin arbiter:
// request/release inputs and the registered grant outputs.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       done;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter: one grant is held until done, request drop or an
// optional maximum hold time, with a one-cycle dead gap between grants.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic         clk,
  input  logic         rst,
  rr_arbiter8_if.slave bus
);

  localparam int unsigned HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam bit LIMIT_EN = (MAX_HOLD != 0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // First set request at or after the pointer, searching upward modulo 8.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] sel;
    logic [2:0] cand;
    logic       found;
    sel   = 3'd0;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      cand = p + 3'(k);
      if (!found && r[cand]) begin
        sel   = cand;
        found = 1'b1;
      end else begin
        sel   = sel;
      end
    end
    return sel;
  endfunction

  function automatic logic [7:0] idx_to_onehot(input logic [2:0] i);
    return 8'd1 << i;
  endfunction

  state_t              state_r;
  state_t              state_n_s;
  logic [2:0]          ptr_r;
  logic [2:0]          ptr_n_s;
  logic [HOLD_W-1:0]   hold_r;
  logic [HOLD_W-1:0]   hold_n_s;
  logic [7:0]          gnt_r;
  logic [7:0]          gnt_n_s;
  logic [2:0]          gnt_idx_r;
  logic [2:0]          gnt_idx_n_s;
  logic                gnt_valid_r;
  logic                gnt_valid_n_s;
  logic                timeout_r;
  logic                timeout_n_s;

  logic [2:0]          win_s;
  logic                rel_done_s;
  logic                rel_drop_s;
  logic                rel_limit_s;
  logic                release_s;

  assign win_s       = rr_pick(bus.req, ptr_r);
  assign rel_done_s  = bus.done;
  assign rel_drop_s  = ~bus.req[gnt_idx_r];
  assign rel_limit_s = LIMIT_EN && (hold_r == HOLD_LIMIT);
  assign release_s   = rel_done_s | rel_drop_s | rel_limit_s;

  // Next-state and next-output decode for the IDLE/GRANT machine.
  always_comb begin
    state_n_s     = state_r;
    ptr_n_s       = ptr_r;
    hold_n_s      = hold_r;
    gnt_n_s       = gnt_r;
    gnt_idx_n_s   = gnt_idx_r;
    gnt_valid_n_s = gnt_valid_r;
    timeout_n_s   = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.req != 8'd0) begin
          state_n_s     = ST_GRANT;
          gnt_n_s       = idx_to_onehot(win_s);
          gnt_idx_n_s   = win_s;
          gnt_valid_n_s = 1'b1;
          hold_n_s      = HOLD_W'(1);
        end else begin
          state_n_s     = ST_IDLE;
          gnt_n_s       = 8'd0;
          gnt_idx_n_s   = 3'd0;
          gnt_valid_n_s = 1'b0;
          hold_n_s      = '0;
        end
      end

      ST_GRANT: begin
        if (release_s) begin
          state_n_s     = ST_IDLE;
          ptr_n_s       = gnt_idx_r + 3'd1;
          gnt_n_s       = 8'd0;
          gnt_idx_n_s   = 3'd0;
          gnt_valid_n_s = 1'b0;
          hold_n_s      = '0;
          // A force-release only counts as a timeout when the owner neither finished nor dropped.
          timeout_n_s   = rel_limit_s & ~rel_done_s & ~rel_drop_s;
        end else if (LIMIT_EN && (hold_r != HOLD_LIMIT)) begin
          hold_n_s      = hold_r + HOLD_W'(1);
        end else begin
          hold_n_s      = hold_r;
        end
      end

      default: begin
        state_n_s     = ST_IDLE;
        ptr_n_s       = 3'd0;
        hold_n_s      = '0;
        gnt_n_s       = 8'd0;
        gnt_idx_n_s   = 3'd0;
        gnt_valid_n_s = 1'b0;
        timeout_n_s   = 1'b0;
      end
    endcase
  end

  // State, pointer, hold counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ptr_r       <= 3'd0;
      hold_r      <= '0;
      gnt_r       <= 8'd0;
      gnt_idx_r   <= 3'd0;
      gnt_valid_r <= 1'b0;
      timeout_r   <= 1'b0;
    end else begin
      state_r     <= state_n_s;
      ptr_r       <= ptr_n_s;
      hold_r      <= hold_n_s;
      gnt_r       <= gnt_n_s;
      gnt_idx_r   <= gnt_idx_n_s;
      gnt_valid_r <= gnt_valid_n_s;
      timeout_r   <= timeout_n_s;
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.gnt_idx   = gnt_idx_r;
  assign bus.gnt_valid = gnt_valid_r;
  assign bus.timeout   = timeout_r;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Cycle-by-cycle vector bench for rr_arbiter8: one instance at the default
// MAX_HOLD driven from a table, one at MAX_HOLD = 4 driven by hand sequences.
module tb_rr_arbiter8;

  typedef struct packed {
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [2:0] idx;
    logic       valid;
    logic       timeout;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  rr_arbiter8_if bus_a ();
  rr_arbiter8_if bus_b ();

  rr_arbiter8 u_dut (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  rr_arbiter8 #(.MAX_HOLD(4)) u_dut4 (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  always #5 clk = ~clk;

  int    n_vec  = 0;
  int    n_miss = 0;
  string cur_name = "";
  vec_t  exp_q[$];
  vec_t  tbl[$];

  function automatic vec_t mk(input logic r, input logic [7:0] q, input logic d,
                              input logic [2:0] i, input logic v, input logic t);
    vec_t x;
    x.rst = r; x.req = q; x.done = d; x.idx = i; x.valid = v; x.timeout = t;
    return x;
  endfunction

  task automatic check(input bit use4);
    vec_t       e;
    logic [7:0] eg;
    logic [7:0] ag;
    logic [2:0] ai;
    logic       av;
    logic       at;
    e = exp_q.pop_front();
    if (use4) begin
      ag = bus_b.gnt; ai = bus_b.gnt_idx; av = bus_b.gnt_valid; at = bus_b.timeout;
    end else begin
      ag = bus_a.gnt; ai = bus_a.gnt_idx; av = bus_a.gnt_valid; at = bus_a.timeout;
    end
    eg = e.valid ? (8'd1 << e.idx) : 8'd0;
    n_vec++;
    if (ag !== eg || ai !== e.idx || av !== e.valid || at !== e.timeout) begin
      n_miss++;
      $display("FAIL %s vec %0d: got gnt=%b idx=%0d valid=%b timeout=%b, required gnt=%b idx=%0d valid=%b timeout=%b",
               cur_name, n_vec, ag, ai, av, at, eg, e.idx, e.valid, e.timeout);
    end
    if (!$onehot0(ag) || (av !== (ag != 8'd0)) || (av && (ag != (8'd1 << ai)))) begin
      n_miss++;
      $display("FAIL %s onehot vec %0d: gnt=%b idx=%0d valid=%b", cur_name, n_vec, ag, ai, av);
    end
  endtask

  task automatic step(input bit use4, input vec_t v);
    @(negedge clk);
    if (use4) begin
      rst_b = v.rst; bus_b.req = v.req; bus_b.done = v.done;
    end else begin
      rst_a = v.rst; bus_a.req = v.req; bus_a.done = v.done;
    end
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    check(use4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_a.req = 8'd0; bus_a.done = 1'b0;
    bus_b.req = 8'd0; bus_b.done = 1'b0;

    // single requester, done after three cycles, then ptr probe and done in IDLE
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h01, 1'b0, 3'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h01, 1'b0, 3'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h01, 1'b0, 3'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h01, 1'b1, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h03, 1'b0, 3'd1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h03, 1'b1, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0));
    // two requesters alternate 0,7,0,7
    tbl.push_back(mk(1'b1, 8'h81, 1'b0, 3'd0, 1'b0, 1'b0));
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mk(1'b0, 8'h81, 1'b0, 3'd0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 8'h81, 1'b1, 3'd0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 8'h81, 1'b0, 3'd7, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 8'h81, 1'b1, 3'd0, 1'b0, 1'b0));
    end
    // all requesters: 0..7 then wrap to 0
    tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 3'd0, 1'b0, 1'b0));
    for (int k = 0; k < 9; k++) begin
      tbl.push_back(mk(1'b0, 8'hFF, 1'b0, 3'(k % 8), 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 8'hFF, 1'b1, 3'd0, 1'b0, 1'b0));
    end
    // request drop releases without timeout; new requests ignored while granted
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h04, 1'b0, 3'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h04, 1'b0, 3'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h0C, 1'b0, 3'd3, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h0E, 1'b0, 3'd3, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h0E, 1'b1, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h0E, 1'b0, 3'd1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h0E, 1'b1, 3'd0, 1'b0, 1'b0));
    // reset mid-GRANT on idx 5 sends the next grant back to idx 1
    tbl.push_back(mk(1'b1, 8'h22, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h22, 1'b0, 3'd1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h22, 1'b1, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h22, 1'b0, 3'd5, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h22, 1'b0, 3'd5, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 8'h22, 1'b0, 3'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 8'h22, 1'b0, 3'd1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h22, 1'b1, 3'd0, 1'b0, 1'b0));
    // default limit: held 16 cycles, timeout pulse, re-grant
    tbl.push_back(mk(1'b1, 8'h10, 1'b0, 3'd0, 1'b0, 1'b0));
    for (int k = 0; k < 16; k++) begin
      tbl.push_back(mk(1'b0, 8'h10, 1'b0, 3'd4, 1'b1, 1'b0));
    end
    tbl.push_back(mk(1'b0, 8'h10, 1'b0, 3'd0, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 8'h10, 1'b0, 3'd4, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 8'h10, 1'b1, 3'd0, 1'b0, 1'b0));

    cur_name = "table";
    for (int i = 0; i < tbl.size(); i++) begin
      step(1'b0, tbl[i]);
    end

    // MAX_HOLD = 4: four-cycle grant, timeout, re-grant, then done coinciding with the limit
    cur_name = "maxhold4";
    step(1'b1, mk(1'b1, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
    for (int k = 0; k < 4; k++) step(1'b1, mk(1'b0, 8'h10, 1'b0, 3'd4, 1'b1, 1'b0));
    step(1'b1, mk(1'b0, 8'h10, 1'b0, 3'd0, 1'b0, 1'b1));
    for (int k = 0; k < 4; k++) step(1'b1, mk(1'b0, 8'h10, 1'b0, 3'd4, 1'b1, 1'b0));
    step(1'b1, mk(1'b0, 8'h10, 1'b1, 3'd0, 1'b0, 1'b0));
    // after a release at idx 4 the pointer is 5, so idx 0 beats idx 4
    cur_name = "reeligible";
    step(1'b1, mk(1'b0, 8'h11, 1'b0, 3'd0, 1'b1, 1'b0));
    step(1'b1, mk(1'b0, 8'h11, 1'b1, 3'd0, 1'b0, 1'b0));
    step(1'b1, mk(1'b0, 8'h10, 1'b0, 3'd4, 1'b1, 1'b0));
    // request drop coinciding with the limit gives no timeout
    cur_name = "drop_at_limit";
    for (int k = 0; k < 3; k++) step(1'b1, mk(1'b0, 8'h10, 1'b0, 3'd4, 1'b1, 1'b0));
    step(1'b1, mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));
    step(1'b1, mk(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
RR_ARBITER8 -- requirements
Module: rr_arbiter8

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 16, the maximum number of consecutive cycles one grant may be held; 0 disables the limit.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 req  input  8  request lines; bit i = requester i wants the shared resource.
REQ-006 done  input  1  owner releases the resource; sampled only in GRANT.
REQ-007 gnt  output  8  one-hot grant vector, registered.
REQ-008 gnt_idx  output  3  binary index of the granted requester, registered; equals the 8:3 encoding of gnt.
REQ-009 gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-010 timeout  output  1  single-cycle pulse when a grant is force-released by MAX_HOLD.

Function
REQ-011 FSM states SHALL be IDLE and GRANT only.
REQ-012 IDLE with req == 0: SHALL stay in IDLE with gnt = 0, gnt_idx = 0 and gnt_valid = 0.
REQ-013 IDLE with req != 0: SHALL select the first set bit at or after ptr, searching upward modulo 8.
  - On the next edge: gnt = one-hot(winner), gnt_idx = winner, gnt_valid = 1, state = GRANT, hold counter = 1.
  - Latency: req sampled at edge N gives gnt visible after edge N.
REQ-014 GRANT SHALL hold gnt, gnt_idx and gnt_valid stable until a release condition occurs.
REQ-015 Release conditions, evaluated at each edge in GRANT:
  - (a) done = 1;
  - (b) req[gnt_idx] = 0;
  - (c) MAX_HOLD != 0 and hold counter == MAX_HOLD.
REQ-016 On any release SHALL:
  - update ptr = (gnt_idx + 1) mod 8;
  - clear gnt, gnt_idx and gnt_valid;
  - return to IDLE.
  This gives a one-cycle dead gap between consecutive grants.
REQ-017 timeout SHALL pulse high for the one cycle after a release caused only by (c); if (a) or (b) coincides with (c), timeout SHALL stay 0.
REQ-018 The hold counter SHALL increment once per cycle in GRANT and saturate at MAX_HOLD; its width SHALL be sufficient for MAX_HOLD without wrap.
REQ-019 ptr wrap-around: a grant to index 7 SHALL set ptr = 0.
REQ-020 Requests arriving while in GRANT SHALL have no effect until IDLE; done is ignored in IDLE.
REQ-021 gnt SHALL never have more than one bit set, and gnt_idx SHALL always match gnt.
REQ-022 A requester force-released by timeout whose req stays high SHALL be re-eligible.
  - It wins again only if no other requester sits between ptr and it in round-robin order.

Reset
REQ-023 rst = 1 at an edge SHALL set:
  - state = IDLE, ptr = 0, hold counter = 0;
  - gnt = 0, gnt_idx = 0, gnt_valid = 0, timeout = 0.
REQ-024 rst SHALL take priority over every other input, including mid-GRANT; the first grant after reset uses ptr = 0.

Verification
REQ-025 Reset then req = 8'b0000_0001, done pulsed after 3 cycles:
  - gnt = 8'b0000_0001, gnt_idx = 3'd0, gnt_valid = 1 one edge after req;
  - all cleared the edge after done;
  - ptr = 1.
REQ-026 Reset then req = 8'b1000_0001 held, done pulsed in every GRANT:
  - grant order is idx 0, 7, 0, 7;
  - one IDLE cycle between each grant.
REQ-027 Reset then req = 8'b1111_1111 held, done pulsed per grant:
  - grant order is idx 0,1,2,3,4,5,6,7,0 (ptr wrap from 7 to 0);
  - gnt_idx is the binary encoding of one-hot gnt every cycle.
REQ-028 MAX_HOLD = 4, req = 8'b0001_0000 held, done = 0:
  - granted for exactly 4 cycles;
  - timeout = 1 for one cycle at release;
  - re-granted to idx 4 after one IDLE cycle.
REQ-029 Granted to idx 2 (req = 8'b0000_0100), then req[2] dropped with no done:
  - release on that edge, timeout stays 0, ptr = 3.
REQ-030 rst asserted for one cycle mid-GRANT (idx 5), req = 8'b0010_0010 held:
  - outputs are 0 after the reset edge;
  - next grant goes to idx 1 (ptr reset to 0).
